// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide unit for the RISC-V execute stage.
// Handles one operation at a time, taking WIDTH cycles per operation.
module mul_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultHi,
    output logic [WIDTH-1:0] resultLo,
    output logic             divByZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]    cnt;
    logic             op_q;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mb;

    logic             last;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] nhi;
    logic [WIDTH-1:0] nlo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;
    logic             fin_dz;

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // hi:lo is the product register (mul) or remainder:quotient (div)
    always_comb begin
        mul_sum = {1'b0, hi} + {1'b0, (lo[0] ? mb : {WIDTH{1'b0}})};
        sh      = {hi, lo[WIDTH-1]};
        nhi     = mul_sum[WIDTH:1];
        nlo     = {mul_sum[0], lo[WIDTH-1:1]};
        if (op_q) begin
            if (sh >= {1'b0, mb}) begin
                nhi = WIDTH'(sh - {1'b0, mb});
                nlo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                nhi = sh[WIDTH-1:0];
                nlo = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Negating a zero remainder stays +0, so no extra fixup needed
    always_comb begin
        prod   = {nhi, nlo};
        fin_dz = 1'b0;
        if (op_q) begin
            fin_dz = (mb == '0);
            fin_hi = sa ? -nhi : nhi;
            fin_lo = (sa ^ sb) ? -nlo : nlo;
            if (fin_dz) fin_lo = '1;
        end else begin
            if (sa ^ sb) prod = -prod;
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            op_q      <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            mb        <= '0;
            resultHi  <= '0;
            resultLo  <= '0;
            divByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '0;
                        op_q <= op;
                        sa   <= opA[WIDTH-1];
                        sb   <= opB[WIDTH-1];
                        hi   <= '0;
                        lo   <= opA[WIDTH-1] ? -opA : opA;
                        mb   <= opB[WIDTH-1] ? -opB : opB;
                    end
                end
                CALC: begin
                    hi  <= nhi;
                    lo  <= nlo;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        resultHi  <= fin_hi;
                        resultLo  <= fin_lo;
                        divByZero <= fin_dz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
